// File: rtl/vip_hex_line_writer_if.sv
// Stream bundle for vip_hex_line_writer: word ingress and ASCII byte egress.
// The master side feeds words and sinks bytes; the slave side is the formatter.
interface vip_hex_line_writer_if #(
  parameter int DATA_WIDTH_P = 32
);
  logic                    ing_tvalid;
  logic                    ing_tready;
  logic [DATA_WIDTH_P-1:0] ing_tdata;
  logic                    egr_tvalid;
  logic                    egr_tready;
  logic [7:0]              egr_tdata;
  logic                    egr_tlast;

  modport master (
    output ing_tvalid, ing_tdata, egr_tready,
    input  ing_tready, egr_tvalid, egr_tdata, egr_tlast
  );

  modport slave (
    input  ing_tvalid, ing_tdata, egr_tready,
    output ing_tready, egr_tvalid, egr_tdata, egr_tlast
  );
endinterface

// File: rtl/vip_hex_line_writer.sv
// Formats each ingress word as one text line: DATA_WIDTH_P/4 hex chars, MSB
// nibble first, then LF. Egress byte outputs are registered and hold under stall.
module vip_hex_line_writer #(
  parameter int DATA_WIDTH_P     = 32,
  parameter int UPPER_CASE_P     = 0,
  parameter int LINE_CNT_WIDTH_P = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  vip_hex_line_writer_if.slave        bus,
  output logic [LINE_CNT_WIDTH_P-1:0] lines_written,
  output logic                        busy
);
  localparam int NCHAR = DATA_WIDTH_P / 4;
  localparam int CNT_W = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [CNT_W-1:0] LAST_CHAR = CNT_W'(NCHAR - 1);
  localparam logic [7:0] LF = 8'h0A;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEX  = 2'd1;
  localparam logic [1:0] EOL  = 2'd2;

  logic [1:0]                  state;
  logic [DATA_WIDTH_P-1:0]     shift_q;
  logic [DATA_WIDTH_P-1:0]     shift_next;
  logic [CNT_W-1:0]            char_cnt;
  logic [7:0]                  tdata_q;
  logic                        tvalid_q;
  logic                        tlast_q;
  logic [LINE_CNT_WIDTH_P-1:0] lines_q;
  logic                        ing_ready;
  logic                        capture;
  logic                        egr_hs;

  function automatic logic [7:0] nib2char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return ((UPPER_CASE_P != 0) ? 8'h37 : 8'h57) + {4'h0, nib};
  endfunction

  // Ingress opens in IDLE, and in EOL only together with the LF handshake so
  // the next word is captured without a bubble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ing_ready = 1'b0;
    case (state)
      IDLE:    ing_ready = 1'b1;
      EOL:     ing_ready = bus.egr_tready;
      default: ing_ready = 1'b0;
    endcase
  end

  assign capture    = bus.ing_tvalid & ing_ready;
  assign egr_hs     = tvalid_q & bus.egr_tready;
  assign shift_next = shift_q << 4;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the edge only, and all state uses non-blocking
    // assignments so every flop sees pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      char_cnt <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      lines_q  <= '0;
    end else begin
      if (capture) begin
        state    <= HEX;
        shift_q  <= bus.ing_tdata;
        char_cnt <= LAST_CHAR;
        tdata_q  <= nib2char(bus.ing_tdata[DATA_WIDTH_P-1 -: 4]);
        tvalid_q <= 1'b1;
        tlast_q  <= 1'b0;
      end else if (egr_hs) begin
        case (state)
          HEX: begin
            if (char_cnt == '0) begin
              tdata_q <= LF;
              tlast_q <= 1'b1;
              state   <= EOL;
            end else begin
              shift_q  <= shift_next;
              tdata_q  <= nib2char(shift_next[DATA_WIDTH_P-1 -: 4]);
              char_cnt <= char_cnt - CNT_W'(1);
            end
          end
          EOL: begin
            state    <= IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
        endcase
      end

      // A line counts as written once its LF has been taken; wraps naturally.
      if (state == EOL && egr_hs) lines_q <= lines_q + LINE_CNT_WIDTH_P'(1);
    end
  end

  assign bus.ing_tready = ing_ready;
  assign bus.egr_tvalid = tvalid_q;
  assign bus.egr_tdata  = tdata_q;
  assign bus.egr_tlast  = tlast_q;
  assign lines_written  = lines_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_vip_hex_line_writer.sv
// Bench for vip_hex_line_writer: a 32-bit lower-case instance (a) and a 16-bit
// upper-case instance with a 4-bit line counter (b), checked against a text model.
module tb_vip_hex_line_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vip_hex_line_writer_if #(.DATA_WIDTH_P(32)) a_if ();
  vip_hex_line_writer_if #(.DATA_WIDTH_P(16)) b_if ();
  logic [15:0] a_lines;
  logic        a_busy;
  logic [3:0]  b_lines;
  logic        b_busy;

  vip_hex_line_writer #(.DATA_WIDTH_P(32), .UPPER_CASE_P(0), .LINE_CNT_WIDTH_P(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if), .lines_written(a_lines), .busy(a_busy));
  vip_hex_line_writer #(.DATA_WIDTH_P(16), .UPPER_CASE_P(1), .LINE_CNT_WIDTH_P(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if), .lines_written(b_lines), .busy(b_busy));

  typedef struct {
    logic ivalid, iready, ovalid, oready, olast, busy;
    logic [31:0] idata, lines;
    logic [7:0]  odata;
  } snap_t;

  typedef struct {
    logic [31:0] word;
    string       line;
    int          lines;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  bit    bp = 1'b0;
  string exp_s [2];
  string got_s [2];
  int    lines_exp [2];
  bit    prev_stall [2];
  logic [7:0] prev_data [2];
  logic  prev_last [2];
  int    got_cyc [$];
  int    acc_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name, input int lim);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no completion within %0d cycles", name, lim);
  endtask

  // Reference: the line is just the zero-padded hex text of the word plus LF.
  function automatic string hex_line(input logic [31:0] w, input int nchar, input bit upper);
    string s;
    s = $sformatf("%08h", w);
    s = s.substr(8 - nchar, 7);
    if (upper) s = s.toupper();
    return {s, "\n"};
  endfunction

  function automatic snap_t snap(input bit s);
    snap_t p;
    p.ivalid = s ? b_if.ing_tvalid : a_if.ing_tvalid;
    p.iready = s ? b_if.ing_tready : a_if.ing_tready;
    p.ovalid = s ? b_if.egr_tvalid : a_if.egr_tvalid;
    p.oready = s ? b_if.egr_tready : a_if.egr_tready;
    p.olast  = s ? b_if.egr_tlast  : a_if.egr_tlast;
    p.odata  = s ? b_if.egr_tdata  : a_if.egr_tdata;
    p.busy   = s ? b_busy : a_busy;
    p.idata  = s ? {16'h0, b_if.ing_tdata} : a_if.ing_tdata;
    p.lines  = s ? {28'h0, b_lines} : {16'h0, a_lines};
    return p;
  endfunction

  // Per-cycle scoreboard, evaluated on the falling edge ahead of the next rising edge.
  task automatic monitor(input bit s);
    snap_t p;
    string pfx;
    int    out;
    logic [7:0] e;
    p   = snap(s);
    pfx = s ? "b" : "a";
    if (!rst_n) begin
      exp_s[s] = "";
      lines_exp[s] = 0;
      prev_stall[s] = 1'b0;
      return;
    end
    out = exp_s[s].len();
    check({pfx, "_lines"}, p.lines, 32'(lines_exp[s] % (s ? 16 : 65536)));
    check({pfx, "_tvalid"}, {31'h0, p.ovalid}, {31'h0, out != 0});
    check({pfx, "_busy"}, {31'h0, p.busy}, {31'h0, out != 0});
    check({pfx, "_ing_tready"}, {31'h0, p.iready}, {31'h0, (out == 0) || (out == 1 && p.oready)});
    if (prev_stall[s]) begin
      check({pfx, "_hold_data"}, {24'h0, p.odata}, {24'h0, prev_data[s]});
      check({pfx, "_hold_last"}, {31'h0, p.olast}, {31'h0, prev_last[s]});
    end
    if (p.ovalid && p.oready && out != 0) begin
      e = exp_s[s][0];
      exp_s[s] = exp_s[s].substr(1, out - 1);
      check({pfx, "_byte"}, {24'h0, p.odata}, {24'h0, e});
      check({pfx, "_tlast"}, {31'h0, p.olast}, {31'h0, e == 8'h0A});
      if (e == 8'h0A) lines_exp[s]++;
      got_s[s] = $sformatf("%s%c", got_s[s], p.odata);
      if (!s) got_cyc.push_back(cyc);
    end
    if (p.ivalid && p.iready) begin
      exp_s[s] = {exp_s[s], hex_line(p.idata, s ? 4 : 8, s)};
      if (!s) acc_cyc.push_back(cyc);
    end
    prev_stall[s] = p.ovalid && !p.oready;
    prev_data[s]  = p.odata;
    prev_last[s]  = p.olast;
  endtask

  always @(negedge clk) begin
    monitor(1'b0);
    monitor(1'b1);
  end

  task automatic step(input bit s);
    @(posedge clk);
    #1;
    if (bp) begin
      if (s) b_if.egr_tready = 1'($urandom_range(0, 1));
      else   a_if.egr_tready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_in(input bit s, input logic v, input logic [31:0] d);
    if (s) begin b_if.ing_tvalid = v; b_if.ing_tdata = d[15:0]; end
    else   begin a_if.ing_tvalid = v; a_if.ing_tdata = d; end
  endtask

  task automatic send(input bit s, input logic [31:0] w, input bit keep);
    set_in(s, 1'b1, w);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s ? b_if.ing_tready : a_if.ing_tready) break;
      if (t == 400) begin timeout("accept", 400); break; end
      step(s);
    end
    step(s);
    if (!keep) set_in(s, 1'b0, w);
  endtask

  task automatic drain(input bit s);
    for (int t = 0; exp_s[s].len() != 0; t++) begin
      if (t == 2000) begin timeout("drain", 2000); break; end
      step(s);
    end
  endtask

  task automatic check_line(input string name, input string got, input string exp);
    check({name, "_len"}, got.len(), exp.len());
    for (int i = 0; i < exp.len(); i++) check(name, {24'h0, got[i]}, {24'h0, exp[i]});
  endtask

  function automatic vec_t mkvec(input logic [31:0] w, input string l, input int n);
    vec_t v;
    v.word = w; v.line = l; v.lines = n;
    return v;
  endfunction

  initial begin
    vec_t vecs [5];
    logic [7:0] dead_bytes [9];
    vecs[0] = mkvec(32'h0000_0001, "00000001\n", 2);
    vecs[1] = mkvec(32'hFFFF_FFFF, "ffffffff\n", 3);
    vecs[2] = mkvec(32'h0000_0000, "00000000\n", 4);
    vecs[3] = mkvec(32'hA5C3_9E71, "a5c39e71\n", 5);
    vecs[4] = mkvec(32'h1000_000F, "1000000f\n", 6);
    dead_bytes = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A};

    set_in(1'b0, 1'b0, 32'h0);
    set_in(1'b1, 1'b0, 32'h0);
    a_if.egr_tready = 1'b1;
    b_if.egr_tready = 1'b1;
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid", {31'h0, a_if.egr_tvalid}, 32'h0);
    check("rst_tdata", {24'h0, a_if.egr_tdata}, 32'h0);
    check("rst_tlast", {31'h0, a_if.egr_tlast}, 32'h0);
    check("rst_lines", {16'h0, a_lines}, 32'h0);
    check("rst_busy", {31'h0, a_busy}, 32'h0);
    check("rst_ing_tready", {31'h0, a_if.ing_tready}, 32'h1);
    step(1'b0);

    // Single word, no backpressure: nine bytes on consecutive cycles after accept.
    got_s[0] = ""; got_cyc.delete(); acc_cyc.delete();
    send(1'b0, 32'hDEAD_BEEF, 1'b0);
    drain(1'b0);
    check("dead_count", got_s[0].len(), 9);
    for (int i = 0; i < 9; i++) begin
      check("dead_byte", {24'h0, got_s[0][i]}, {24'h0, dead_bytes[i]});
      check("dead_cycle", got_cyc[i], acc_cyc[0] + 1 + i);
    end
    check("dead_lines", {16'h0, a_lines}, 32'd1);

    foreach (vecs[k]) begin
      got_s[0] = "";
      send(1'b0, vecs[k].word, 1'b0);
      drain(1'b0);
      check_line("tbl_line", got_s[0], vecs[k].line);
      check("tbl_lines", {16'h0, a_lines}, vecs[k].lines);
    end

    // Back-to-back: second accept lands on the first LF, no valid gap.
    got_s[0] = ""; got_cyc.delete(); acc_cyc.delete();
    send(1'b0, 32'h0123_4567, 1'b1);
    send(1'b0, 32'h89AB_CDEF, 1'b0);
    drain(1'b0);
    check_line("b2b_line", got_s[0], "01234567\n89abcdef\n");
    check("b2b_gapless", got_cyc[17] - got_cyc[0], 17);
    check("b2b_accept_on_lf", acc_cyc[1], got_cyc[8]);

    // Same word under random backpressure.
    bp = 1'b1;
    got_s[0] = "";
    send(1'b0, 32'hDEAD_BEEF, 1'b0);
    drain(1'b0);
    check_line("bp_line", got_s[0], "deadbeef\n");
    check("bp_lines", {16'h0, a_lines}, 32'd9);

    for (int i = 0; i < 40; i++) begin
      bit keep;
      keep = (i != 39) && ($urandom_range(0, 1) == 1);
      send(1'b0, $urandom, keep);
      if (!keep) repeat ($urandom_range(0, 3)) step(1'b0);
    end
    drain(1'b0);
    bp = 1'b0;
    a_if.egr_tready = 1'b1;
    step(1'b0);

    // Reset mid-line after three characters have gone out.
    got_s[0] = "";
    send(1'b0, 32'hDEAD_BEEF, 1'b0);
    repeat (3) step(1'b0);
    check("mid_chars_out", got_s[0].len(), 3);
    rst_n = 1'b0;
    step(1'b0);
    @(negedge clk);
    check("mid_tvalid", {31'h0, a_if.egr_tvalid}, 32'h0);
    check("mid_busy", {31'h0, a_busy}, 32'h0);
    check("mid_lines", {16'h0, a_lines}, 32'h0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    got_s[0] = "";
    send(1'b0, 32'h0, 1'b0);
    drain(1'b0);
    check_line("mid_after", got_s[0], "00000000\n");

    // Upper-case 16-bit instance, then run its 4-bit counter through a wrap.
    got_s[1] = "";
    send(1'b1, 32'h0000_AF09, 1'b0);
    drain(1'b1);
    check_line("b_upper", got_s[1], "AF09\n");
    bp = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      send(1'b1, $urandom, 1'b0);
      drain(1'b1);
      if (k == 15) check("wrap_15", {28'h0, b_lines}, 32'd15);
      if (k == 16) check("wrap_16", {28'h0, b_lines}, 32'd0);
      if (k == 17) check("wrap_17", {28'h0, b_lines}, 32'd1);
    end
    bp = 1'b0;
    step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/vip_hex_line_writer.md
# vip_hex_line_writer

Streaming text formatter: each data word accepted on an AXI-Stream-style ingress is written out as one ASCII text line, a fixed number of hex characters, MSB nibble first, terminated by LF (0x0A). It is the write side of the team's text-file dump format, which the file-reading helpers consume one whitespace-delimited token per line. The byte egress feeds a UART transmitter or a simulation file-dump sink.

## Interface
- DATA_WIDTH_P, 32, ingress word width; must be a multiple of 4, with a minimum of 4
- UPPER_CASE_P, 0, 0: hex digits a-f map to 0x61-0x66; 1: A-F map to 0x41-0x46
- LINE_CNT_WIDTH_P, 16, width of the lines-written counter
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, synchronous and active-low
- ing_tvalid  in  1  ingress word valid
- ing_tready  out  1  ingress ready
- ing_tdata  in  DATA_WIDTH_P  word to format
- egr_tvalid  out  1  egress byte valid
- egr_tready  in  1  egress ready
- egr_tdata  out  8  ASCII byte
- egr_tlast  out  1  high only on the LF byte of each line
- lines_written  out  LINE_CNT_WIDTH_P  count of completed lines; wraps modulo 2^LINE_CNT_WIDTH_P
- busy  out  1  high while a line is in progress (state != IDLE)

## Operation
- NCHAR = DATA_WIDTH_P/4 hex characters per line, followed by 1 LF byte.
- States:
  - IDLE: ing_tready=1, egr_tvalid=0.
    - On ing_tvalid: latch ing_tdata into the shift register, load the char for nibble NCHAR-1 into egr_tdata, set egr_tvalid=1, set char_cnt=NCHAR-1, go to HEX.
  - HEX: egr_tvalid=1.
    - On egr_tready: if char_cnt==0, load egr_tdata=0x0A, egr_tlast=1 and go to EOL; else shift left 4, load the next nibble's char, decrement char_cnt.
  - EOL: egr_tvalid=1, egr_tlast=1, ing_tready=egr_tready.
    - On egr_tready, lines_written increments.
    - If ing_tvalid is also high, behave as the IDLE capture and go to HEX with no bubble.
    - Otherwise go to IDLE with egr_tvalid=0 and egr_tlast=0.
- ing_tready is 0 in HEX; it is combinational from egr_tready only in EOL.
- Nibble to char mapping: 0-9 map to 0x30+n. 10-15 map to 0x57+n (lower case) or 0x37+n (upper case).
- egr_tdata, egr_tvalid and egr_tlast are registered and must hold stable while egr_tvalid=1 and egr_tready=0 (AXI-Stream rule).
- No leading-zero suppression: 32'h0000_0001 writes "00000001\n".

## Timing
- Reset values: egr_tvalid=0, egr_tdata=8'h00, egr_tlast=0, lines_written=0, busy=0, state=IDLE. ing_tready=1 in the cycle after reset is released.
- Latency: a word accepted at edge t gives its first char valid after edge t (cycle t+1).
- Throughput: with egr_tready held at 1 and ing_tvalid continuously high, one word per NCHAR+1 cycles with no idle cycle between lines.
- lines_written updates at the edge where the LF handshake completes; it is visible the following cycle.
- Reset asserted mid-line: the next edge returns everything to reset values. The partial line is dropped; no LF is emitted and the count is unchanged from reset (0).
- Egress backpressure at any point stalls the FSM with no loss or duplication of characters.
- lines_written at its maximum value wraps to 0 on the next completed line.

## Test plan
- Lower case, single word: ing_tdata=32'hDEADBEEF with egr_tready=1.
  - Egress bytes are 0x64 0x65 0x61 0x64 0x62 0x65 0x65 0x66 0x0A on 9 consecutive cycles starting 1 cycle after accept.
  - egr_tlast is high only on 0x0A; lines_written=1 afterwards.
- Back-to-back: words 32'h01234567 then 32'h89ABCDEF with ing_tvalid held high.
  - Output is 18 bytes, "01234567\n89abcdef\n", with no egr_tvalid gap.
  - The second ing_tready handshake coincides with the first LF handshake.
- Backpressure: same stimulus as the first scenario, with egr_tready random at 50%.
  - The byte sequence is identical.
  - egr_tdata is stable whenever egr_tvalid=1 and egr_tready=0.
  - ing_tready stays 0 until the LF handshake.
- Upper case: UPPER_CASE_P=1, DATA_WIDTH_P=16, word 16'hAF09.
  - Egress bytes are 0x41 0x46 0x30 0x39 0x0A.
- Reset mid-line: assert rst_n=0 after 3 chars of 32'hDEADBEEF have been accepted.
  - The next cycle shows egr_tvalid=0, busy=0, lines_written=0.
  - A subsequent word 32'h0 then gives "00000000\n".
- Counter wrap: LINE_CNT_WIDTH_P=4, write 17 words.
  - lines_written goes 15 then 0 on the 16th LF, and reads 1 after the 17th LF.
